// File: rtl/div_iter_unit_pkg.sv
// Shared types for the iterative divider.
//   div_op_e     : operation select (DIV_S, DIV_U, REM_S, REM_U)
//   div_states_e : divider FSM states (D_IDLE, D_INIT, D_CALC, D_SIGN)
//   is_signed_op / is_rem_op : decode helpers for div_op_e
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_S = 2'd0,
    DIV_U = 2'd1,
    REM_S = 2'd2,
    REM_U = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_INIT = 2'd1,
    D_CALC = 2'd2,
    D_SIGN = 2'd3
  } div_states_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == REM_S) || (op == REM_U);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   i_rem  : partial remainder entering the step (always < i_div)
//   i_msb  : next dividend bit shifted into the remainder
//   i_div  : divisor magnitude
//   o_rem  : partial remainder leaving the step
//   o_qbit : quotient bit produced by the step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Since i_rem < i_div, the shifted value is < 2*i_div, so bit WIDTH of the
  // WIDTH+1-bit difference is exactly the borrow of the trial subtraction.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative integer divider (DIV, DIVU, REM, REMU, RISC-V M semantics).
// Retires STEPS quotient bits per cycle; divide-by-zero and signed overflow
// finish straight from D_INIT.
//   clk, reset : clock, synchronous active-high reset
//   start_i    : request, accepted only in D_IDLE and only without kill_i
//   kill_i     : abort the current operation, no done_o for it
//   op_i, a_i, b_i : operation and operands, captured with start_i
//   busy_o     : FSM not in D_IDLE
//   done_o     : one-cycle pulse, result_o valid
//   result_o   : quotient or remainder, held until the next completion
// Handshake: a request is taken on any clock edge where start_i=1, kill_i=0
// and busy_o=0; its completion is the single cycle with done_o=1, during which
// busy_o is already low so the next request may be taken in that same cycle.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             kill_i,
  input  div_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);

  div_states_e      r_state, w_next_state;
  div_op_e          r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_rem;   // partial remainder
  logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] r_div;   // divisor magnitude
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q, r_sign_r, r_done;
  logic             w_done_set;

  logic             w_signed, w_rem_op, w_div_zero, w_ovf, w_fast;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fast_result;
  logic [WIDTH-1:0] w_quo_fin, w_rem_fin, w_final;
  logic [WIDTH-1:0] w_rem_chain [STEPS+1];
  logic [STEPS-1:0] w_qbits;
  logic [WIDTH-1:0] w_quo_next;

  assign w_signed   = is_signed_op(r_op);
  assign w_rem_op   = is_rem_op(r_op);
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = w_signed && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
  assign w_fast     = w_div_zero || w_ovf;
  assign w_abs_a    = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b    = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Divide-by-zero: q = all ones, r = a. Overflow: q = a, r = 0.
  always_comb begin
    w_fast_result = '0;
    if (w_rem_op) w_fast_result = w_div_zero ? r_a : '0;
    else          w_fast_result = w_div_zero ? '1  : r_a;
  end

  assign w_quo_fin = r_sign_q ? -r_quo : r_quo;
  assign w_rem_fin = r_sign_r ? -r_rem : r_rem;
  assign w_final   = w_rem_op ? w_rem_fin : w_quo_fin;

  // STEPS chained steps; step 0 consumes the current dividend MSB.
  assign w_rem_chain[0] = r_rem;
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (w_rem_chain[gi]),
      .i_msb  (r_quo[WIDTH-1-gi]),
      .i_div  (r_div),
      .o_rem  (w_rem_chain[gi+1]),
      .o_qbit (w_qbits[STEPS-1-gi])
    );
  end
  assign w_quo_next = {r_quo[WIDTH-STEPS-1:0], w_qbits};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= D_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; kill_i overrides everything
  always_comb begin
    w_next_state = r_state;
    if (kill_i) begin
      w_next_state = D_IDLE;
    end else begin
      case (r_state)
        D_IDLE: if (start_i) w_next_state = D_INIT;
        D_INIT: w_next_state = w_fast ? D_IDLE : D_CALC;
        D_CALC: if (r_cnt == CW'(1)) w_next_state = D_SIGN;
        D_SIGN: w_next_state = D_IDLE;
        default: w_next_state = D_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy_o     = (r_state != D_IDLE);
    w_done_set = !kill_i && (((r_state == D_INIT) && w_fast) || (r_state == D_SIGN));
  end

  assign done_o   = r_done;
  assign result_o = r_result;

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= DIV_S;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_set;
      case (r_state)
        D_IDLE: begin
          if (start_i && !kill_i) begin
            r_op <= op_i;
            r_a  <= a_i;
            r_b  <= b_i;
          end
        end
        D_INIT: begin
          r_sign_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_sign_r <= w_signed && r_a[WIDTH-1];
          r_rem    <= '0;
          r_quo    <= w_abs_a;
          r_div    <= w_abs_b;
          r_cnt    <= CW'(N);
          if (w_fast && !kill_i) r_result <= w_fast_result;
        end
        D_CALC: begin
          r_rem <= w_rem_chain[STEPS];
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CW'(1);
        end
        D_SIGN: begin
          if (!kill_i) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: 32/1
  logic        reset0 = 1'b1, start0 = 1'b0, kill0 = 1'b0;
  div_op_e     op0 = DIV_U;
  logic [31:0] a0 = '0, b0 = '0;
  logic        busy0, done0;
  logic [31:0] res0;

  // DUT1: 32/4, DUT2: 16/2
  logic        rst_aux = 1'b1, kill_aux = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  div_op_e     op1 = DIV_U, op2 = DIV_U;
  logic [31:0] a1 = '0, b1 = '0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        busy1, done1, busy2, done2;
  logic [31:0] res1;
  logic [15:0] res2;

  div_iter_unit #(.WIDTH(32), .STEPS(1)) u_dut0 (
    .clk(clk), .reset(reset0), .start_i(start0), .kill_i(kill0), .op_i(op0),
    .a_i(a0), .b_i(b0), .busy_o(busy0), .done_o(done0), .result_o(res0));

  div_iter_unit #(.WIDTH(32), .STEPS(4)) u_dut1 (
    .clk(clk), .reset(rst_aux), .start_i(start1), .kill_i(kill_aux), .op_i(op1),
    .a_i(a1), .b_i(b1), .busy_o(busy1), .done_o(done1), .result_o(res1));

  div_iter_unit #(.WIDTH(16), .STEPS(2)) u_dut2 (
    .clk(clk), .reset(rst_aux), .start_i(start2), .kill_i(kill_aux), .op_i(op2),
    .a_i(a2), .b_i(b2), .busy_o(busy2), .done_o(done2), .result_o(res2));

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: signed/unsigned integer division on w-bit values.
  function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    longint m    = (64'sd1 << w) - 1;
    longint half = 64'sd1 << (w - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint sa, sb, q, r;
    bit sgn = (op == DIV_S) || (op == REM_S);
    bit rem = (op == REM_S) || (op == REM_U);
    if (ub == 0) return 32'(rem ? ua : m);
    if (sgn) begin
      sa = (ua >= half) ? ua - (64'sd1 << w) : ua;
      sb = (ub >= half) ? ub - (64'sd1 << w) : ub;
      if (sa == -half && sb == -1) return 32'(rem ? 64'sd0 : ua);
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return 32'((rem ? r : q) & m);
  endfunction

  function automatic int latency(input div_op_e op, input logic [31:0] a,
                                 input logic [31:0] b, input int w, input int steps);
    logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    logic [31:0] mn = 32'd1 << (w - 1);
    bit sgn = (op == DIV_S) || (op == REM_S);
    if ((b & m) == 0) return 2;
    if (sgn && (a & m) == mn && (b & m) == m) return 2;
    return w / steps + 3;
  endfunction

  // Scoreboard for DUT0: expected result, due cycle, start cycle
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          beg_q[$];
  bit          busy_chk = 1'b1;
  bit          checking = 1'b0;
  bit          exp_busy;

  always @(negedge clk) begin
    if (checking && !reset0) begin
      if (exp_q.size() > 0 && due_q[0] == cyc) begin
        check("done0", done0, 1);
        check("result0", res0, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(beg_q.pop_front());
      end else begin
        check("no_done0", done0, 0);
      end
      if (busy_chk) begin
        exp_busy = (exp_q.size() > 0) && (cyc > beg_q[0]) && (cyc < due_q[0]);
        check("busy0", busy0, exp_busy);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; the start is taken at the following posedge.
  task automatic issue0(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
    op0 = op; a0 = a; b0 = b; start0 = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + latency(op, a, b, 32, 1));
      beg_q.push_back(cyc);
    end
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic abort0(input bit use_reset, input logic [31:0] exp_res);
    busy_chk = 1'b0;
    issue0(DIV_U, 32'd1000, 32'd3, 32'd0, 1'b0);   // now at t+1
    repeat (9) @(negedge clk);                       // t+10
    if (use_reset) reset0 = 1'b1; else kill0 = 1'b1;
    @(negedge clk);                                  // t+11
    reset0 = 1'b0; kill0 = 1'b0;
    check(use_reset ? "rst_busy" : "kill_busy", busy0, 0);
    check(use_reset ? "rst_result" : "kill_result", res0, exp_res);
    busy_chk = 1'b1;
    repeat (40) @(negedge clk);                      // no late done_o allowed
  endtask

  task automatic run1(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    int t, lat;
    bit got;
    @(negedge clk);
    op1 = op; a1 = a; b1 = b; start1 = 1'b1; t = cyc;
    @(negedge clk);
    start1 = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (done1) begin got = 1'b1; lat = cyc - t; end
      else @(negedge clk);
    end
    check("s4_done", got, 1);
    check("s4_latency", lat, latency(op, a, b, 32, 4));
    check("s4_result", res1, model(op, a, b, 32));
  endtask

  task automatic run2(input div_op_e op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp, input int exp_lat);
    int t, lat;
    bit got;
    @(negedge clk);
    op2 = op; a2 = a; b2 = b; start2 = 1'b1; t = cyc;
    @(negedge clk);
    start2 = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (done2) begin got = 1'b1; lat = cyc - t; end
      else @(negedge clk);
    end
    check("w16_done", got, 1);
    check("w16_latency", lat, exp_lat);
    check("w16_result", res2, exp);
  endtask

  logic [31:0] ops_tab [10] = '{32'd0, 32'd1, 32'd7, 32'd1000, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFF9,
                                32'd3, 32'h1234_5678};

  // ---------------- main sequence ----------------
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_result", res0, 0);
    reset0 = 1'b0; rst_aux = 1'b0;
    @(negedge clk);
    checking = 1'b1;

    // Hand-computed values pinning the model
    check("m_divs", model(DIV_S, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFD);
    check("m_rems", model(REM_S, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFF);
    check("m_divu", model(DIV_U, 32'd100, 32'd7, 32), 32'd14);
    check("m_remu", model(REM_U, 32'd100, 32'd7, 32), 32'd2);
    check("m_div0", model(DIV_U, 32'd5, 32'd0, 32), 32'hFFFF_FFFF);
    check("m_ovf",  model(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h8000_0000);
    check("m_w16",  model(DIV_S, 32'h8000, 32'hFFFF, 16), 32'h8000);

    // Signed divide / remainder of -7 by 2
    issue0(DIV_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1); drain0();
    issue0(REM_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1); drain0();

    // Back-to-back: second start in the first op's done_o cycle
    t = cyc;
    issue0(DIV_U, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (34) @(negedge clk);
    check("b2b_at_done", cyc - t, 35);
    issue0(REM_U, 32'd100, 32'd7, 32'd2, 1'b1);
    drain0();

    // Divide-by-zero fast path
    issue0(DIV_S, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1); drain0();
    issue0(REM_U, 32'd5, 32'd0, 32'd5, 1'b1); drain0();

    // Kill mid-operation keeps the previous result (5), then a clean op
    abort0(1'b0, 32'd5);
    issue0(DIV_U, 32'd9, 32'd3, 32'd3, 1'b1); drain0();

    // Reset mid-operation clears the result
    abort0(1'b1, 32'd0);
    issue0(DIV_U, 32'd9, 32'd3, 32'd3, 1'b1); drain0();

    // Signed overflow fast path, and the same operands unsigned
    issue0(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); drain0();
    issue0(REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1); drain0();
    issue0(DIV_U, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1); drain0();

    // Kill and start together in D_IDLE: start dropped
    kill0 = 1'b1;
    issue0(DIV_U, 32'd50, 32'd5, 32'd0, 1'b0);
    kill0 = 1'b0;
    check("kill_start_busy", busy0, 0);
    repeat (40) @(negedge clk);
    checking = 1'b0;

    // 32/4 sweep
    run1(DIV_S, 32'hFFFF_FFF9, 32'd2);
    run1(REM_U, 32'd100, 32'd7);
    for (int i = 0; i < 16; i++)
      run1(div_op_e'($urandom_range(0, 3)), ops_tab[$urandom_range(0, 9)],
           ops_tab[$urandom_range(0, 9)]);

    // 16/2
    run2(DIV_S, 16'h8000, 16'hFFFF, 16'h8000, 2);
    run2(DIV_S, 16'h8000, 16'h0002, 16'hC000, 11);
    run2(REM_S, 16'hFFF9, 16'h0002, 16'hFFFF, 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
